// File: rtl/adder_pkg.sv
// Shared defaults and the elaboration-time width check for the pipelined adder.
package adder_pkg;

    localparam int ADDER_WIDTH  = 32;
    localparam int ADDER_STAGES = 4;

    // True when WIDTH splits into STAGES equal, non-empty chunks.
    function automatic bit adder_width_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/add_stage.sv
// Combinational CHUNK-bit adder slice with carry in/out; one per pipeline stage.
module add_stage
    import adder_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_cout
);

    logic [CHUNK:0] w_total;

    assign w_total = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};
    assign o_sum   = w_total[CHUNK-1:0];
    assign o_cout  = w_total[CHUNK];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined adder/subtractor: one CHUNK-bit slice per stage, carry registered between
// stages, valid/ready handshake with bubble-collapsing backpressure.
module pipe_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = ADDER_WIDTH,
    parameter int STAGES = ADDER_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rslt,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = WIDTH / STAGES;

    if (!adder_width_ok(WIDTH, STAGES)) begin : g_bad_width
        $error("pipe_adder: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
    end

    // Stage gi consumes the low CHUNK bits of its a/b inputs; the remaining operand
    // bits are shifted down as they move on, and finished sum chunks enter the result
    // from the top so that after STAGES shifts the result is aligned.
    logic [WIDTH-1:0]  w_a_in   [STAGES];
    logic [WIDTH-1:0]  w_b_in   [STAGES];
    logic [WIDTH-1:0]  w_res_in [STAGES];
    logic              w_c_in   [STAGES];
    logic              w_sub_in [STAGES];
    logic [STAGES-1:0] w_valid_in;
    logic [STAGES-1:0] w_valid;
    logic [STAGES-1:0] w_load;
    logic [STAGES-1:0] w_drain;

    assign w_a_in[0]     = a;
    assign w_b_in[0]     = b ^ {WIDTH{sub}};
    assign w_c_in[0]     = cin ^ sub;
    assign w_sub_in[0]   = sub;
    assign w_res_in[0]   = '0;
    assign w_valid_in[0] = in_valid;

    // Ready ripples back from the output: a stage may load when empty or when the
    // stage after it is taking its contents this cycle.
    always_comb begin
        w_load              = '0;
        w_drain             = '0;
        w_drain[STAGES-1]   = out_ready;
        w_load[STAGES-1]    = !w_valid[STAGES-1] | out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            w_drain[k] = w_load[k+1];
            w_load[k]  = !w_valid[k] | w_drain[k];
        end
    end

    assign in_ready = w_load[0];

    genvar gi;
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
        logic [CHUNK-1:0] w_sum;
        logic             w_carry;
        logic [WIDTH-1:0] w_sum_ext;
        logic [WIDTH-1:0] w_res_next;

        add_stage #(.CHUNK(CHUNK)) u_add (
            .i_a    (w_a_in[gi][CHUNK-1:0]),
            .i_b    (w_b_in[gi][CHUNK-1:0]),
            .i_cin  (w_c_in[gi]),
            .o_sum  (w_sum),
            .o_cout (w_carry)
        );

        assign w_sum_ext  = WIDTH'(w_sum);
        assign w_res_next = (w_res_in[gi] >> CHUNK) | (w_sum_ext << (WIDTH - CHUNK));

        if (gi < STAGES - 1) begin : g_mid
            logic             r_valid;
            logic             r_c;
            logic             r_sub;
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;
            logic [WIDTH-1:0] r_res;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid <= 1'b0;
                end else if (w_load[gi]) begin
                    r_valid <= w_valid_in[gi];
                    r_a     <= w_a_in[gi] >> CHUNK;
                    r_b     <= w_b_in[gi] >> CHUNK;
                    r_res   <= w_res_next;
                    r_c     <= w_carry;
                    r_sub   <= w_sub_in[gi];
                end
            end

            assign w_valid[gi]      = r_valid;
            assign w_valid_in[gi+1] = r_valid;
            assign w_a_in[gi+1]     = r_a;
            assign w_b_in[gi+1]     = r_b;
            assign w_res_in[gi+1]   = r_res;
            assign w_c_in[gi+1]     = r_c;
            assign w_sub_in[gi+1]   = r_sub;
        end else begin : g_last
            logic             r_valid;
            logic [WIDTH-1:0] r_rslt;
            logic             r_cout;
            logic             r_ovf;

            // The top chunk's MSBs are the operand sign bits, so overflow is decided here.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid <= 1'b0;
                    r_rslt  <= '0;
                    r_cout  <= 1'b0;
                    r_ovf   <= 1'b0;
                end else if (w_load[gi]) begin
                    r_valid <= w_valid_in[gi];
                    r_rslt  <= w_res_next;
                    r_cout  <= w_carry ^ w_sub_in[gi];
                    r_ovf   <= (w_a_in[gi][CHUNK-1] == w_b_in[gi][CHUNK-1])
                             & (w_sum[CHUNK-1] != w_a_in[gi][CHUNK-1]);
                end
            end

            assign w_valid[gi] = r_valid;
            assign out_valid   = r_valid;
            assign rslt        = r_rslt;
            assign cout        = r_cout;
            assign ovf         = r_ovf;
        end
    end

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: three builds (STAGES=4, 1, 32) share stimulus; each has its own
// scoreboard fed by an arithmetic reference model.
module tb_pipe_adder;

    typedef struct {
        logic [31:0] r;
        logic        co;
        logic        ov;
        int          acc;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] er;
        logic        eco;
        logic        eov;
    } vec_t;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        out_ready;

    logic [2:0]  in_ready_d;
    logic [2:0]  out_valid_d;
    logic [2:0]  cout_d;
    logic [2:0]  ovf_d;
    logic [31:0] rslt_d [3];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   chk_lat = 0;

    exp_t ring [3][64];
    int   head [3];
    int   tail [3];
    int   acc_cnt [3];
    int   out_cnt [3];
    bit   seen [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipe_adder #(.WIDTH(32), .STAGES(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_d[0]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_d[0]),
        .out_ready(out_ready), .rslt(rslt_d[0]), .cout(cout_d[0]), .ovf(ovf_d[0])
    );
    pipe_adder #(.WIDTH(32), .STAGES(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_d[1]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_d[1]),
        .out_ready(out_ready), .rslt(rslt_d[1]), .cout(cout_d[1]), .ovf(ovf_d[1])
    );
    pipe_adder #(.WIDTH(32), .STAGES(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_d[2]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_d[2]),
        .out_ready(out_ready), .rslt(rslt_d[2]), .cout(cout_d[2]), .ovf(ovf_d[2])
    );

    function automatic int lat(input int d);
        case (d)
            0:       return 4;
            1:       return 1;
            default: return 32;
        endcase
    endfunction

    // Reference: plain integer arithmetic on 64-bit values.
    function automatic exp_t ref_calc(input logic [31:0] x, input logic [31:0] y,
                                      input logic c, input logic s);
        exp_t   e;
        longint ux, uy, sx, sy, u, sr;
        ux = longint'({32'h0, x});
        uy = longint'({32'h0, y});
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!s) begin
            u    = ux + uy + longint'(c);
            sr   = sx + sy + longint'(c);
            e.co = (u >= 64'sh1_0000_0000);
        end else begin
            u    = ux - uy - longint'(c);
            sr   = sx - sy - longint'(c);
            e.co = (ux < uy + longint'(c));
        end
        e.r   = u[31:0];
        e.ov  = (sr > SMAX) || (sr < SMIN);
        e.acc = 0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every presented result must match the oldest outstanding beat.
    always @(negedge clk) begin
        if (rst) begin
            for (int d = 0; d < 3; d++) begin
                head[d] <= 0;
                tail[d] <= 0;
                seen[d] <= 0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (out_valid_d[d]) begin
                    if (head[d] == tail[d]) begin
                        chk($sformatf("dut%0d unexpected_output", d), 64'(out_valid_d[d]), 64'd0);
                    end else begin
                        chk($sformatf("dut%0d result", d),
                            {31'd0, cout_d[d], ovf_d[d], rslt_d[d]},
                            {31'd0, ring[d][head[d] % 64].co, ring[d][head[d] % 64].ov,
                             ring[d][head[d] % 64].r});
                        if (chk_lat && !seen[d])
                            chk($sformatf("dut%0d latency", d),
                                64'(cyc - ring[d][head[d] % 64].acc), 64'(lat(d)));
                        seen[d] <= 1;
                        if (out_ready) begin
                            head[d]    <= head[d] + 1;
                            seen[d]    <= 0;
                            out_cnt[d] <= out_cnt[d] + 1;
                        end
                    end
                end
                if (in_valid && in_ready_d[d]) begin
                    ring[d][tail[d] % 64]     <= ref_calc(a, b, cin, sub);
                    ring[d][tail[d] % 64].acc <= cyc;
                    tail[d]    <= tail[d] + 1;
                    acc_cnt[d] <= acc_cnt[d] + 1;
                end
            end
        end
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_payload();
        a   = pick();
        b   = pick();
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
    endtask

    task automatic drain(input string name);
        bit done;
        done = 0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(posedge clk);
            #1;
            done = (head[0] == tail[0]) && (head[1] == tail[1]) && (head[2] == tail[2])
                && (out_valid_d == 3'b000);
        end
        chk(name, 64'(done), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    vec_t        vecs [8];
    logic [31:0] pa [6];
    logic [31:0] pb [6];
    logic        pc [6];
    logic        ps [6];

    initial begin
        int  idx, acc0, out0, outs [3];
        bit  acc;

        for (int d = 0; d < 3; d++) begin
            acc_cnt[d] = 0;
            out_cnt[d] = 0;
        end
        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0};
        vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1};
        vecs[4] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[7] = '{32'h1234_5678, 32'h1234_5677, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b0};

        rst = 1; in_valid = 0; a = 0; b = 0; cin = 0; sub = 0; out_ready = 1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset dut%0d out_valid", d), 64'(out_valid_d[d]), 64'd0);
            chk($sformatf("reset dut%0d in_ready", d), 64'(in_ready_d[d]), 64'd1);
            chk($sformatf("reset dut%0d outputs", d), {cout_d[d], ovf_d[d], rslt_d[d]}, 64'd0);
        end
        @(posedge clk); #1 rst = 0;

        // Directed vectors, one beat at a time; exact cycle of appearance per build.
        foreach (vecs[i]) begin
            @(posedge clk); #1;
            a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin; sub = vecs[i].sub; in_valid = 1;
            @(negedge clk);
            chk($sformatf("vec%0d in_ready", i), 64'(in_ready_d), 64'h7);
            @(posedge clk); #1 in_valid = 0;
            for (int k = 1; k <= 33; k++) begin
                @(negedge clk);
                for (int d = 0; d < 3; d++) begin
                    if (k == lat(d)) begin
                        chk($sformatf("vec%0d dut%0d valid", i, d), 64'(out_valid_d[d]), 64'd1);
                        chk($sformatf("vec%0d dut%0d rslt", i, d), 64'(rslt_d[d]), 64'(vecs[i].er));
                        chk($sformatf("vec%0d dut%0d cout", i, d), 64'(cout_d[d]), 64'(vecs[i].eco));
                        chk($sformatf("vec%0d dut%0d ovf", i, d), 64'(ovf_d[d]), 64'(vecs[i].eov));
                    end else if (k == lat(d) - 1 || k == lat(d) + 1) begin
                        chk($sformatf("vec%0d dut%0d idle k=%0d", i, d, k), 64'(out_valid_d[d]), 64'd0);
                    end
                end
            end
        end

        // Throughput: 16 back-to-back beats with the consumer always ready.
        for (int d = 0; d < 3; d++) outs[d] = out_cnt[d];
        chk_lat = 1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            rand_payload();
            in_valid = 1;
        end
        @(posedge clk); #1 in_valid = 0;
        drain("throughput drain");
        chk_lat = 0;
        for (int d = 0; d < 3; d++)
            chk($sformatf("throughput dut%0d count", d), 64'(out_cnt[d] - outs[d]), 64'd16);

        // Backpressure on the 4-stage build: 6 beats offered with out_ready low.
        for (int i = 0; i < 6; i++) begin
            pa[i] = $urandom; pb[i] = $urandom;
            pc[i] = 1'($urandom_range(0, 1)); ps[i] = 1'($urandom_range(0, 1));
        end
        acc0 = acc_cnt[0];
        out0 = out_cnt[0];
        out_ready = 0;
        idx = 0;
        a = pa[0]; b = pb[0]; cin = pc[0]; sub = ps[0]; in_valid = 1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            acc = in_valid && in_ready_d[0];
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 6) begin a = pa[idx]; b = pb[idx]; cin = pc[idx]; sub = ps[idx]; end
                else in_valid = 0;
            end
        end
        chk("stall accepted", 64'(acc_cnt[0] - acc0), 64'd4);
        @(negedge clk);
        chk("stall in_ready", 64'(in_ready_d[0]), 64'd0);
        chk("stall out_valid", 64'(out_valid_d[0]), 64'd1);
        @(posedge clk); #1 out_ready = 1;
        for (int n = 0; n < 50 && idx < 6; n++) begin
            @(negedge clk);
            acc = in_valid && in_ready_d[0];
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 6) begin a = pa[idx]; b = pb[idx]; cin = pc[idx]; sub = ps[idx]; end
                else in_valid = 0;
            end
        end
        in_valid = 0;
        chk("stall all accepted", 64'(idx), 64'd6);
        drain("stall drain");
        chk("stall emitted", 64'(out_cnt[0] - out0), 64'd6);

        // Reset with three beats in flight: nothing from the 4- and 32-stage builds appears.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            rand_payload();
            in_valid = 1;
        end
        @(posedge clk); #1 in_valid = 0; rst = 1;
        @(posedge clk); #1 rst = 0;
        out0 = out_cnt[0];
        outs[2] = out_cnt[2];
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("midreset dut%0d out_valid", d), 64'(out_valid_d[d]), 64'd0);
            chk($sformatf("midreset dut%0d in_ready", d), 64'(in_ready_d[d]), 64'd1);
        end
        repeat (40) @(posedge clk);
        #1;
        chk("midreset dut0 emitted", 64'(out_cnt[0] - out0), 64'd0);
        chk("midreset dut2 emitted", 64'(out_cnt[2] - outs[2]), 64'd0);

        // Random traffic with random backpressure; payload held while the 4-stage build stalls.
        for (int d = 0; d < 3; d++) outs[d] = acc_cnt[d] - out_cnt[d];
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            acc = in_valid && in_ready_d[0];
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 2) != 0);
                rand_payload();
            end
        end
        in_valid = 0;
        out_ready = 1;
        drain("random drain");
        for (int d = 0; d < 3; d++)
            chk($sformatf("random dut%0d in==out", d), 64'(acc_cnt[d] - out_cnt[d]), 64'(outs[d]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
Parametrised, pipelined two's-complement adder/subtractor. It is the successor to the 16-bit ripple-carry adder.
- Operand width is split into STAGES equal chunks. Each pipeline stage adds one chunk and registers the carry, so clock rate is set by a CHUNK-bit ripple rather than a WIDTH-bit ripple.
- Uses a valid/ready handshake with full backpressure. It sits between the ALU issue logic and the writeback buffer.

Parameters:
- WIDTH, 32, operand/result width in bits; must be divisible by STAGES.
- STAGES, 4, number of pipeline stages; 1..WIDTH. CHUNK = WIDTH/STAGES.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand beat presented.
- in_ready  out  1  block accepts the beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) or borrow-in (sub).
- sub  in  1  0: a+b+cin; 1: a-b-cin.
- out_valid  out  1  result beat presented.
- out_ready  in  1  consumer accepts the result.
- rslt  out  WIDTH  sum/difference modulo 2^WIDTH.
- cout  out  1  add: carry-out; sub: borrow-out (1 when a < b+cin unsigned).
- ovf  out  1  signed overflow.

Behaviour:
- Reset: rst=1 at a rising edge clears every stage valid bit.
  - out_valid=0, rslt=0, cout=0, ovf=0 during the cycle after that edge.
  - in_ready=1 during that cycle.
  - Reset mid-operation discards all in-flight beats; nothing is emitted.
- Transfer rule: input transfer occurs when in_valid & in_ready at a rising edge; output transfer occurs when out_valid & out_ready at a rising edge.
- Payload must hold stable while valid is high and ready is low; the block's own outputs obey this.
- Arithmetic:
  - Effective B is b^{WIDTH{sub}`}; effective carry-in is cin^sub.
  - Chunk k (bits k*CHUNK .. k*CHUNK+CHUNK-1) is added in stage k, using the registered carry of stage k-1 (stage 0 uses the effective carry-in).
  - Final carry c: cout = c^sub.
  - ovf = (A[W-1] == Beff[W-1]) & (rslt[W-1] != A[W-1]).
- Stage registers: stage k holds a valid bit, the completed low result bits, the remaining unprocessed high bits of a and effective b, the carry, and sub.
  - The last stage's register drives the outputs directly, with no combinational path from inputs to outputs.
- Latency: a beat accepted at edge t is presented with out_valid=1 in the cycle after edge t+STAGES-1, i.e. STAGES cycles. With out_ready held at 1, throughput is 1 beat/cycle.
- Flow control, bubble-collapsing:
  - stage k may load when !valid_k or stage k is draining; the last stage drains on out_ready.
  - in_ready = !valid_0 | drain_0.
  - in_ready may depend combinationally on out_ready.
- Capacity and stall:
  - Capacity is STAGES beats.
  - With out_ready=0 the pipeline fills; in_ready falls once all stages are valid.
  - No beat is lost, duplicated or reordered.
- Simultaneous events:
  - Full pipeline with out_ready=1 and in_valid=1 in the same cycle: accept and emit in that cycle.
  - rst overrides all handshakes.
- STAGES=1: a single registered WIDTH-bit add with 1-cycle latency.

Decomposition:
- Shared package adder_pkg holds:
  - the default WIDTH/STAGES constants;
  - a width-check function flagging WIDTH%STAGES != 0 at elaboration.
- Sub-module add_stage (parameter CHUNK): combinational CHUNK-bit add with carry in/out. It is instantiated STAGES times in a generate loop; registers stay in pipe_adder.

Test Plan (WIDTH=32, STAGES=4 unless noted):
1. Add overflow: a=0xFFFFFFFF, b=1, cin=0, sub=0, out_ready=1 -> 4 cycles later rslt=0x00000000, cout=1, ovf=0.
2. Signed overflow: a=0x7FFFFFFF, b=1, sub=0 -> rslt=0x80000000, cout=0, ovf=1. Subtraction cases:
   - sub=1, a=5, b=7, cin=0 -> rslt=0xFFFFFFFE, cout=1, ovf=0.
   - sub=1, a=0x80000000, b=1 -> rslt=0x7FFFFFFF, cout=0, ovf=1.
3. Throughput: 16 back-to-back random beats, in_valid=1, out_ready=1 -> one result per cycle, first at cycle 4, all matching the reference model, in order.
4. Backpressure: out_ready=0, in_valid=1 with 6 beats -> exactly 4 accepted, in_ready=0 afterwards. Raise out_ready -> 6 results in order, no duplicates, outputs stable while stalled.
5. Reset mid-flight: 3 beats accepted, rst=1 for 1 cycle -> out_valid=0 and in_ready=1 the next cycle; none of the 3 results ever appears.
6. STAGES=1 and STAGES=32 builds: repeat scenarios 1–3 -> latency 1 and 32 cycles respectively, identical results.
